risc_fetch_unit: RTL and testbench
==================================

// Module: risc_fetch_unit
// PURPOSE
//  Instruction-fetch stage upstream of risc_cpu decode: owns the PC, issues pipelined reads to instruction memory,
//  buffers returned words in a small prefetch FIFO, and hands {instr, pc} to decode over a valid/ready handshake.
//  Accepts branch/jump redirects from downstream, flushes stale instructions, and discards in-flight responses.
// PARAMETERS
//  WIDTH       32  PC / address-path width
//  ADDR_WIDTH  8   instruction-memory address width (imem_addr = fetch_pc[ADDR_WIDTH-1:0])
//  FIFO_DEPTH  4   prefetch entries; power of 2, >= 2; also the max outstanding requests
//  RESET_PC    0   PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clk             in   1           clock, rising edge
//  reset           in   1           asynchronous, active-high
//  imem_req        out  1           read request valid
//  imem_gnt        in   1           memory accepts request this cycle (req && gnt = issued)
//  imem_addr       out  ADDR_WIDTH  byte address of request
//  imem_rvalid     in   1           read data valid; responses return in request order, latency >= 1
//  imem_rdata      in   32          read data
//  redirect_valid  in   1           redirect fetch to redirect_pc (1-cycle pulse)
//  redirect_pc     in   WIDTH       new PC; bits [1:0] ignored (forced 0)
//  halt            in   1           stop issuing new requests; in-flight ones complete normally
//  inst_valid      out  1           FIFO head valid
//  inst_ready      in   1           decode consumes head (valid && ready = pop)
//  inst_data       out  32          head instruction
//  inst_pc         out  WIDTH       PC of head instruction
//  pc_out          out  WIDTH       next fetch PC (debug)
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=S_BOOT; imem_req=0,
//   imem_addr=RESET_PC[ADDR_WIDTH-1:0], inst_valid=0, inst_data=0, inst_pc=0, pc_out=RESET_PC.
//  FSM: S_BOOT -> S_RUN unconditionally on first clock after reset release (no request in S_BOOT).
//   S_RUN stays until reset; reset mid-operation drops FIFO, counters, and in-flight tracking instantly.
//  Issue: imem_req = S_RUN && !halt && (fifo_count + outstanding < FIFO_DEPTH) && !redirect_valid.
//   On req&&gnt: fetch_pc += 4 (mod 2^WIDTH, wraps 0xFFFF_FFFC -> 0), outstanding += 1.
//   imem_addr/imem_req held stable until granted.
//  Response: on imem_rvalid, outstanding -= 1; if drop_cnt>0 word is discarded and drop_cnt -= 1,
//   else {imem_rdata, pc tag} pushed. Pc tag = separate response_pc counter, +4 per accepted word.
//  Credit rule guarantees no push when full; push-while-full is an assertion failure, not handled.
//  Output: inst_* driven from FIFO head register; latency rvalid -> inst_valid = 1 cycle (no bypass).
//   inst_data/inst_pc hold while inst_valid && !inst_ready. Simultaneous push+pop: count unchanged.
//  Redirect (priority over everything in same cycle): FIFO flushed (a same-cycle pop is moot),
//   fetch_pc = response_pc = {redirect_pc[WIDTH-1:2],2'b00}, drop_cnt = outstanding_next where
//   outstanding_next counts requests still in flight after this cycle's rvalid (same-cycle rvalid word is dropped).
//   imem_req forced 0 in redirect cycle; issue resumes next cycle. New requests may issue while drop_cnt>0.
//  Redirect while drop_cnt>0: drop_cnt recomputed = outstanding_next (superset, still correct).
//  halt: inst_* handshake continues; deasserting halt resumes issue from fetch_pc next cycle.
//  inst_valid never asserts for a word requested before the last redirect.
// STRUCTURE
//  risc_pkg: INSTR_WIDTH=32, PC_STEP=4, fetch state enum {S_BOOT,S_RUN}.
//  Sub-module risc_fetch_fifo (DEPTH, DATA_WIDTH=32+WIDTH): sync FIFO, flush input, count output,
//   registered head outputs. Top holds FSM, PCs, outstanding/drop counters.
// TESTING
//  1. Reset, gnt=1, rvalid 1 cycle after grant, ready=1 -> inst_pc 0,4,8,... back-to-back, first inst_valid 3 clks after reset release.
//  2. ready=0 for 10 cycles -> exactly 4 words buffered, imem_req drops to 0, no overflow; ready=1 drains PCs in order.
//  3. Redirect to 0x40 with 2 requests outstanding -> both responses discarded, next inst_pc=0x40, no stale inst_valid.
//  4. Redirect coinciding with rvalid and pop -> FIFO empty next cycle, that word dropped, fetch resumes at redirect_pc.
//  5. gnt held low 5 cycles -> imem_addr stable; RESET_PC=0xFFFF_FFF8 -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  6. Assert reset mid-stream with 3 buffered + 2 outstanding -> all outputs at reset values same cycle, late rvalids after S_BOOT ignored only if rvalid withheld by bench (bench resets memory too).

Source files
------------

// File: rtl/risc_pkg.sv
// Shared fetch-stage types and constants.
// No ports: INSTR_WIDTH, PC_STEP, fetch FSM state enum.
package risc_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_STEP     = 4;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/risc_fetch_fifo.sv
// Prefetch FIFO: sync, flushable, head driven from storage.
// Ports: clk, reset, i_flush, i_push, i_pop, i_data,
//        o_valid, o_data (0 when empty), o_count.
module risc_fetch_fifo
  import risc_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = INSTR_WIDTH + 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_flush,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [DATA_WIDTH-1:0]     i_data,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr;
  logic [PW-1:0]         r_rd;
  logic [CW-1:0]         r_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_do_pop;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_do_pop = i_pop && !w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push)   r_wr <= r_wr + 1'b1;
      if (w_do_pop) r_rd <= r_rd + 1'b1;
      unique case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd];
  assign o_count = r_count;

  // Upstream credit accounting must never let a push land on a full FIFO.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
      !(i_push && !i_flush && w_full));

endmodule

// File: rtl/risc_fetch_unit.sv
// Fetch stage: PC, pipelined imem reads, prefetch FIFO, redirect.
// Ports: clk, reset, imem req/gnt/addr/rvalid/rdata, redirect,
//        halt, inst valid/ready/data/pc, pc_out (next fetch PC).
module risc_fetch_unit
  import risc_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               ADDR_WIDTH = 8,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   o_imem_req,
  input  logic                   i_imem_gnt,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic                   i_imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  input  logic                   i_redirect_valid,
  input  logic [WIDTH-1:0]       i_redirect_pc,
  input  logic                   i_halt,
  output logic                   o_inst_valid,
  input  logic                   i_inst_ready,
  output logic [INSTR_WIDTH-1:0] o_inst_data,
  output logic [WIDTH-1:0]       o_inst_pc,
  output logic [WIDTH-1:0]       o_pc_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = INSTR_WIDTH + WIDTH;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nx;
  logic            w_run;

  logic [WIDTH-1:0] r_fetch_pc;
  logic [WIDTH-1:0] r_resp_pc;
  logic [CW-1:0]    r_outst;
  logic [CW-1:0]    r_drop;
  logic [CW-1:0]    w_outst_nx;
  logic [CW-1:0]    w_count;
  logic [CW:0]      w_inuse;
  logic             w_credit;
  logic             w_issue;
  logic             w_drop;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_redir_pc;
  logic [DW-1:0]    w_head;
  logic             w_unused;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_BOOT;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_BOOT:  w_state_nx = S_RUN;
      S_RUN:   w_state_nx = S_RUN;
      default: w_state_nx = S_BOOT;
    endcase
  end

  always_comb begin
    w_run = (r_state == S_RUN);
  end

  // Buffered plus in-flight words may never exceed FIFO slots.
  assign w_inuse  = {1'b0, w_count} + {1'b0, r_outst};
  assign w_credit = w_inuse < (CW+1)'(FIFO_DEPTH);

  assign o_imem_req = w_run && !i_halt && w_credit
                   && !i_redirect_valid;
  assign w_issue    = o_imem_req && i_imem_gnt;

  assign w_outst_nx = r_outst + CW'(w_issue)
                    - CW'(i_imem_rvalid);

  assign w_drop = i_imem_rvalid && (r_drop != '0);
  assign w_push = i_imem_rvalid && !w_drop
               && !i_redirect_valid;
  assign w_pop  = o_inst_valid && i_inst_ready;

  assign w_redir_pc = {i_redirect_pc[WIDTH-1:2], 2'b00};
  assign w_unused   = ^i_redirect_pc[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
    end else begin
      r_outst <= w_outst_nx;
      if (i_redirect_valid) begin
        // Everything still in flight after this cycle is stale.
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
        r_drop     <= w_outst_nx;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + STEP;
        if (w_push)  r_resp_pc  <= r_resp_pc + STEP;
        if (w_drop)  r_drop     <= r_drop - 1'b1;
      end
    end
  end

  risc_fetch_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .DATA_WIDTH (DW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (i_redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({i_imem_rdata, r_resp_pc}),
    .o_valid (o_inst_valid),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign o_inst_data = w_head[DW-1:WIDTH];
  assign o_inst_pc   = w_head[WIDTH-1:0];
  assign o_imem_addr = r_fetch_pc[ADDR_WIDTH-1:0];
  assign o_pc_out    = r_fetch_pc;

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Directed bench for risc_fetch_unit with in-order imem model.
// Popped {pc,data} are logged and compared to hand values.
module tb_risc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        req;
  logic        gnt;
  logic [7:0]  addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rdr_v;
  logic [31:0] rdr_pc;
  logic        halt;
  logic        ivalid;
  logic        iready;
  logic [31:0] idata;
  logic [31:0] ipc;
  logic [31:0] pc_out;

  logic        hi_req;
  logic [7:0]  hi_addr;
  logic        hi_valid;
  logic [31:0] hi_data;
  logic [31:0] hi_ipc;
  logic [31:0] hi_pc_out;

  int n_chk;
  int n_fail;

  logic [7:0]  rq[$];
  logic [31:0] lpc[$];
  logic [31:0] ldat[$];
  logic        hold;

  risc_fetch_unit u_dut (
    .clk              (clk),
    .reset            (reset),
    .o_imem_req       (req),
    .i_imem_gnt       (gnt),
    .o_imem_addr      (addr),
    .i_imem_rvalid    (rvalid),
    .i_imem_rdata     (rdata),
    .i_redirect_valid (rdr_v),
    .i_redirect_pc    (rdr_pc),
    .i_halt           (halt),
    .o_inst_valid     (ivalid),
    .i_inst_ready     (iready),
    .o_inst_data      (idata),
    .o_inst_pc        (ipc),
    .o_pc_out         (pc_out)
  );

  risc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_hi (
    .clk              (clk),
    .reset            (reset),
    .o_imem_req       (hi_req),
    .i_imem_gnt       (gnt),
    .o_imem_addr      (hi_addr),
    .i_imem_rvalid    (1'b0),
    .i_imem_rdata     (32'h0),
    .i_redirect_valid (1'b0),
    .i_redirect_pc    (32'h0),
    .i_halt           (1'b1),
    .o_inst_valid     (hi_valid),
    .i_inst_ready     (1'b0),
    .o_inst_data      (hi_data),
    .o_inst_pc        (hi_ipc),
    .o_pc_out         (hi_pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [7:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes at negedge, answer after posedge.
  task automatic tick();
    logic       iss;
    logic [7:0] ia;
    @(negedge clk);
    iss = req && gnt;
    ia  = addr;
    if (ivalid && iready) begin
      lpc.push_back(ipc);
      ldat.push_back(idata);
    end
    @(posedge clk);
    if (iss && !reset) rq.push_back(ia);
    #1;
    if (!hold && rq.size() > 0) begin
      rvalid = 1'b1;
      rdata  = word(rq.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic redirect(input logic [31:0] pc);
    rdr_v  = 1'b1;
    rdr_pc = pc;
    tick();
    rdr_v  = 1'b0;
  endtask

  task automatic clr_log();
    lpc.delete();
    ldat.delete();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    gnt    = 1'b1;
    rvalid = 1'b0;
    rdata  = 32'h0;
    rdr_v  = 1'b0;
    rdr_pc = 32'h0;
    halt   = 1'b0;
    iready = 1'b1;
    hold   = 1'b0;

    // Reset values
    ticks(2);
    chk("rst_valid", {31'h0, ivalid}, 32'h0);
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_addr", {24'h0, addr}, 32'h0);
    chk("rst_data", idata, 32'h0);
    chk("rst_ipc", ipc, 32'h0);
    chk("hi_pc_out", hi_pc_out, 32'hFFFF_FFF8);
    chk("hi_addr", {24'h0, hi_addr}, 32'hF8);
    chk("hi_req", {31'h0, hi_req}, 32'h0);
    chk("hi_valid", {31'h0, hi_valid}, 32'h0);
    chk("hi_data", hi_data, 32'h0);
    chk("hi_ipc", hi_ipc, 32'h0);

    // 1: boot latency and back-to-back stream
    reset = 1'b0;
    tick();
    chk("boot_req", {31'h0, req}, 32'h1);
    chk("boot_v1", {31'h0, ivalid}, 32'h0);
    tick();
    chk("boot_v2", {31'h0, ivalid}, 32'h0);
    chk("boot_pcout", pc_out, 32'h4);
    tick();
    chk("boot_v3", {31'h0, ivalid}, 32'h1);
    chk("boot_ipc", ipc, 32'h0);
    chk("boot_data", idata, word(8'h00));
    clr_log();
    ticks(6);
    chk("s1_n", lpc.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      chk("s1_pc", lpc[i], 32'(4 * i));
    chk("s1_dat", ldat[5], word(8'd20));

    // 2: backpressure fills FIFO, then drains in order
    iready = 1'b0;
    redirect(32'h100);
    ticks(10);
    chk("bp_valid", {31'h0, ivalid}, 32'h1);
    chk("bp_req", {31'h0, req}, 32'h0);
    chk("bp_ipc", ipc, 32'h100);
    chk("bp_data", idata, word(8'h00));
    chk("bp_pcout", pc_out, 32'h110);
    iready = 1'b1;
    clr_log();
    ticks(10);
    for (int i = 0; i < 6; i++)
      chk("bp_pc", lpc[i], 32'h100 + 32'(4 * i));

    // 3: redirect with two responses outstanding
    halt = 1'b1;
    ticks(8);
    hold = 1'b1;
    halt = 1'b0;
    ticks(2);
    chk("r3_empty", {31'h0, ivalid}, 32'h0);
    redirect(32'h43);
    chk("r3_pcout", pc_out, 32'h40);
    chk("r3_v", {31'h0, ivalid}, 32'h0);
    hold = 1'b0;
    clr_log();
    ticks(10);
    chk("r3_pc0", lpc[0], 32'h40);
    chk("r3_dat0", ldat[0], word(8'h40));
    chk("r3_pc1", lpc[1], 32'h44);
    chk("r3_pc2", lpc[2], 32'h48);

    // 4: redirect in a cycle with rvalid and pop
    chk("r4_pre", {31'h0, ivalid}, 32'h1);
    redirect(32'h80);
    chk("r4_empty", {31'h0, ivalid}, 32'h0);
    chk("r4_pcout", pc_out, 32'h80);
    clr_log();
    ticks(8);
    chk("r4_pc0", lpc[0], 32'h80);
    chk("r4_dat0", ldat[0], word(8'h80));
    chk("r4_pc1", lpc[1], 32'h84);

    // 5: grant stall keeps address, then PC wrap
    gnt = 1'b0;
    redirect(32'h60);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("g5_addr", {24'h0, addr}, 32'h60);
    end
    chk("g5_req", {31'h0, req}, 32'h1);
    gnt = 1'b1;
    redirect(32'hFFFF_FFF8);
    clr_log();
    ticks(8);
    chk("w5_pc0", lpc[0], 32'hFFFF_FFF8);
    chk("w5_pc1", lpc[1], 32'hFFFF_FFFC);
    chk("w5_pc2", lpc[2], 32'h0000_0000);
    chk("w5_dat2", ldat[2], word(8'h00));

    // 6: async reset mid-stream
    iready = 1'b0;
    redirect(32'h200);
    ticks(3);
    hold = 1'b1;
    ticks(2);
    chk("r6_pre", {31'h0, ivalid}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("r6_valid", {31'h0, ivalid}, 32'h0);
    chk("r6_req", {31'h0, req}, 32'h0);
    chk("r6_pcout", pc_out, 32'h0);
    chk("r6_addr", {24'h0, addr}, 32'h0);
    chk("r6_data", idata, 32'h0);
    chk("r6_ipc", ipc, 32'h0);
    rq.delete();
    hold   = 1'b0;
    rvalid = 1'b0;
    iready = 1'b1;
    ticks(2);
    reset = 1'b0;
    ticks(3);
    chk("r6_rv", {31'h0, ivalid}, 32'h1);
    chk("r6_rpc", ipc, 32'h0);
    chk("r6_rdat", idata, word(8'h00));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
